// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding, width defaults
// and the wait-counter load helper.
package mem_access_ctrl_pkg;

   localparam int DEF_ADDR_W   = 9;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_READ_LAT = 1;
   localparam int CNT_W        = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_WAIT = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   // The RD cycle already covers one cycle of RAM latency, so WAIT counts the rest.
   function automatic logic [CNT_W-1:0] wait_load(input int read_lat);
      return CNT_W'(read_lat - 1);
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the synchronous single-port RAM: one load/store at a time,
// strobes and address are registered, read data is returned with a one-cycle done pulse.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int READ_LAT = DEF_READ_LAT
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [CNT_W-1:0] LAT_LOAD = wait_load(READ_LAT);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   assign req_ready = (state == ST_IDLE);

   always_ff @(posedge clock) begin
      if (!clear) begin
         state     <= ST_IDLE;
         ram_read  <= 1'b0;
         ram_write <= 1'b0;
         done      <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         rdata     <= '0;
         wait_cnt  <= '0;
      end else begin
         // Strobes and done are single-cycle pulses; only the arms below raise them.
         ram_read  <= 1'b0;
         ram_write <= 1'b0;
         done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  ram_addr <= req_addr;
                  if (req_we) begin
                     ram_wdata <= req_wdata;
                     ram_write <= 1'b1;
                     state     <= ST_WR;
                  end else begin
                     ram_read <= 1'b1;
                     state    <= ST_RD;
                  end
               end
            end
            ST_WR: begin
               done  <= 1'b1;
               state <= ST_RESP;
            end
            ST_RD: begin
               wait_cnt <= LAT_LOAD;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  rdata <= ram_rdata;
                  done  <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against behavioural RAMs (latency 1 and latency 3).
module tb_mem_access_ctrl;

   logic        clock = 1'b0;
   logic        clear;
   logic        req_valid, req_we;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        req_ready, done, ram_read, ram_write;
   logic [31:0] rdata, ram_wdata, ram_rdata;
   logic [8:0]  ram_addr;

   logic        req_valid_b;
   logic [8:0]  req_addr_b;
   logic        req_ready_b, done_b, ram_read_b, ram_write_b;
   logic [31:0] rdata_b, ram_wdata_b, ram_rdata_b;
   logic [8:0]  ram_addr_b;

   logic [31:0] mem_a [512];
   logic [31:0] mem_b [512];
   logic [31:0] sb    [512];
   logic [31:0] pipe_b0, pipe_b1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1)) dut (
      .clock(clock), .clear(clear), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .done(done),
      .rdata(rdata), .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3)) dut_lat3 (
      .clock(clock), .clear(clear), .req_valid(req_valid_b), .req_we(1'b0),
      .req_addr(req_addr_b), .req_wdata(32'd0), .req_ready(req_ready_b), .done(done_b),
      .rdata(rdata_b), .ram_read(ram_read_b), .ram_write(ram_write_b), .ram_addr(ram_addr_b),
      .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
   );

   function automatic logic [31:0] preload(input int i);
      case (i)
         87:      return 32'd43;
         94:      return 32'h0000_0A0A;
         95:      return 32'h0000_0004;
         101:     return 32'h0000_0003;
         130:     return 32'h0000_BEEF;
         default: return 32'hC0DE_0000 + 32'(i);
      endcase
   endfunction

   // Latency-1 RAM
   initial begin
      for (int i = 0; i < 512; i++) mem_a[i] = preload(i);
      forever begin
         @(posedge clock);
         if (ram_write) mem_a[ram_addr] <= ram_wdata;
         if (ram_read)  ram_rdata <= mem_a[ram_addr];
      end
   end

   // Latency-3 RAM: two extra pipeline stages behind the array read
   initial begin
      for (int i = 0; i < 512; i++) mem_b[i] = preload(i);
      forever begin
         @(posedge clock);
         if (ram_write_b) mem_b[ram_addr_b] <= ram_wdata_b;
         if (ram_read_b)  pipe_b0 <= mem_b[ram_addr_b];
         pipe_b1     <= pipe_b0;
         ram_rdata_b <= pipe_b1;
      end
   end

   always @(negedge clock) begin
      if (clear === 1'b1) begin
         n_cmp++;
         if ((ram_read && ram_write) || ((ram_read || ram_write) && req_ready)) begin
            n_bad++;
            $display("FAIL strobe_excl: read=%0b write=%0b ready=%0b, required no overlap and no strobe in IDLE",
                     ram_read, ram_write, req_ready);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Starts at a negedge in IDLE, ends at the negedge of the IDLE cycle after done.
   task automatic txn(input bit we, input logic [8:0] addr, input logic [31:0] wd,
                      input string tag, output int lat, output logic [31:0] rd);
      chk({tag, "/ready_in"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0; req_we = 1'b0; req_addr = ~addr; req_wdata = ~wd;
      chk({tag, "/strobes"}, 32'({ram_write, ram_read}), 32'({we, ~we}));
      chk({tag, "/ram_addr"}, 32'(ram_addr), 32'(addr));
      if (we) chk({tag, "/ram_wdata"}, ram_wdata, wd);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      rd = rdata;
      chk({tag, "/ready_busy"}, 32'(req_ready), 32'd0);
      if (we) sb[addr] = wd;
      @(negedge clock);
      chk({tag, "/done_pulse"}, 32'(done), 32'd0);
   endtask

   typedef struct {
      bit          we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t        tbl [7];
   int          lat;
   logic [31:0] rd, last_rd;
   logic [7:0]  seen_read, seen_done;
   logic [31:0] rd_at3, rd_at7;
   int          done_cnt;

   initial begin
      tbl[0] = '{1'b0, 9'd95,  32'd0,         32'h0000_0004, 3};
      tbl[1] = '{1'b1, 9'd200, 32'h1234_5678, 32'h0000_0004, 2};
      tbl[2] = '{1'b0, 9'd200, 32'd0,         32'h1234_5678, 3};
      tbl[3] = '{1'b0, 9'h1FF, 32'd0,         32'hC0DE_01FF, 3};
      tbl[4] = '{1'b1, 9'h1FF, 32'hFFFF_FFFF, 32'hC0DE_01FF, 2};
      tbl[5] = '{1'b0, 9'h1FF, 32'd0,         32'hFFFF_FFFF, 3};
      tbl[6] = '{1'b0, 9'd0,   32'd0,         32'hC0DE_0000, 3};
      for (int i = 0; i < 512; i++) sb[i] = preload(i);

      clear = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_valid_b = 1'b0; req_addr_b = '0;
      repeat (3) @(negedge clock);
      chk("rst/ready", 32'(req_ready), 32'd1);
      chk("rst/done", 32'(done), 32'd0);
      chk("rst/strobes", 32'({ram_read, ram_write}), 32'd0);
      chk("rst/ram_addr", 32'(ram_addr), 32'd0);
      chk("rst/ram_wdata", ram_wdata, 32'd0);
      chk("rst/rdata", rdata, 32'd0);
      clear = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 7; i++) begin
         txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, $sformatf("vec%0d", i), lat, rd);
         chk($sformatf("vec%0d/latency", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("vec%0d/rdata", i), rd, tbl[i].exp_rd);
      end

      // Busy ignore: request held while the address changes under a busy controller
      seen_read = '0; seen_done = '0; rd_at3 = '0; rd_at7 = '0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 9'd87;
      @(posedge clock);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clock);
         if (c == 1) req_addr = 9'd94;
         seen_read[c] = ram_read;
         seen_done[c] = done;
         if (c == 2) chk("busy/addr_stable", 32'(ram_addr), 32'd87);
         if (c == 3) rd_at3 = rdata;
         if (c == 5) chk("busy/addr_second", 32'(ram_addr), 32'd94);
         if (c == 7) rd_at7 = rdata;
      end
      req_valid = 1'b0;
      chk("busy/read_cycles", 32'(seen_read), 32'b0010_0010);
      chk("busy/done_cycles", 32'(seen_done), 32'b1000_1000);
      chk("busy/rdata_first", rd_at3, 32'd43);
      chk("busy/rdata_second", rd_at7, 32'h0000_0A0A);
      @(negedge clock);

      // Reset during WAIT of a read; a request during reset is not accepted
      req_valid = 1'b1; req_we = 1'b0; req_addr = 9'd130;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      chk("rstrd/read_strobe", 32'(ram_read), 32'd1);
      @(negedge clock);
      clear = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 9'd5; req_wdata = 32'hDEAD_DEAD;
      @(negedge clock);
      chk("rstrd/done", 32'(done), 32'd0);
      chk("rstrd/rdata", rdata, 32'd0);
      chk("rstrd/ready", 32'(req_ready), 32'd1);
      chk("rstrd/strobes", 32'({ram_read, ram_write}), 32'd0);
      clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      done_cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (done) done_cnt++;
      end
      chk("rstrd/no_done", 32'(done_cnt), 32'd0);
      chk("rstrd/ready_after", 32'(req_ready), 32'd1);
      txn(1'b0, 9'd5, 32'd0, "rstrd_rb", lat, rd);
      chk("rstrd/no_write", rd, sb[5]);

      // Reset during WR: the write on that edge still lands
      req_valid = 1'b1; req_we = 1'b1; req_addr = 9'd300; req_wdata = 32'hCAFE_F00D;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0; req_we = 1'b0;
      chk("rstwr/write_strobe", 32'(ram_write), 32'd1);
      clear = 1'b0;
      @(negedge clock);
      chk("rstwr/done", 32'(done), 32'd0);
      chk("rstwr/ram_addr", 32'(ram_addr), 32'd0);
      clear = 1'b1;
      sb[300] = 32'hCAFE_F00D;
      @(negedge clock);
      txn(1'b0, 9'd300, 32'd0, "rstwr_rb", lat, rd);
      chk("rstwr/landed", rd, 32'hCAFE_F00D);

      // READ_LAT=3 instance
      req_valid_b = 1'b1; req_addr_b = 9'd101;
      @(posedge clock);
      @(negedge clock);
      req_valid_b = 1'b0;
      chk("lat3/read_strobe", 32'(ram_read_b), 32'd1);
      lat = 1;
      while (!done_b && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      chk("lat3/latency", 32'(lat), 32'd5);
      chk("lat3/rdata", rdata_b, 32'h0000_0003);
      @(negedge clock);

      // Random mix against the scoreboard
      last_rd = rdata;
      for (int i = 0; i < 50; i++) begin
         bit          we;
         logic [8:0]  addr;
         logic [31:0] wd;
         logic [31:0] exp_rd;
         we = 1'($urandom_range(0, 1));
         addr = 9'($urandom_range(0, 511));
         wd = $urandom;
         exp_rd = we ? last_rd : sb[addr];
         txn(we, addr, wd, $sformatf("rnd%0d", i), lat, rd);
         chk($sformatf("rnd%0d/latency", i), 32'(lat), we ? 32'd2 : 32'd3);
         chk($sformatf("rnd%0d/rdata", i), rd, exp_rd);
         last_rd = exp_rd;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "timeout");
   end

endmodule
